// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO interrupt core: bus width, register address
// type and the register map.
package gpio_pkg;

  localparam int unsigned GPIO_BUS_WIDTH = 32;

  typedef logic [4:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_REG_IN   = 5'd0;
  localparam gpio_addr_t GPIO_REG_OUT  = 5'd1;
  localparam gpio_addr_t GPIO_REG_DIR  = 5'd2;
  localparam gpio_addr_t GPIO_REG_IE   = 5'd3;
  localparam gpio_addr_t GPIO_REG_RISE = 5'd4;
  localparam gpio_addr_t GPIO_REG_FALL = 5'd5;
  localparam gpio_addr_t GPIO_REG_STAT = 5'd6;

endpackage

// File: rtl/gpio_irq_core_if.sv
// Register bus between a bus master and the GPIO interrupt core; rd_data is combinational
// in the slave.
interface gpio_irq_core_if;
  import gpio_pkg::*;

  logic                      cs;
  logic                      read;
  logic                      write;
  gpio_addr_t                reg_addr;
  logic [GPIO_BUS_WIDTH-1:0] wr_data;
  logic [GPIO_BUS_WIDTH-1:0] rd_data;

  modport master (
    output cs, read, write, reg_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, reg_addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/gpio_pin_cond.sv
// Single-pin conditioner: 2-flop synchroniser, optional debounce filter (GPIO_DEBOUNCE_EN)
// and unmasked rise/fall detection against the previous conditioned level.
module gpio_pin_cond
`ifdef GPIO_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pin;
      s2_q   <= s1_q;
      prev_q <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  // The filtered level only moves after the synchronised input has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (s2_q == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= s2_q;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  assign level = filt;
  assign rise  = filt & ~prev_q;
  assign fall  = ~filt & prev_q;

endmodule

// File: rtl/gpio_irq_core.sv
// Parametrised GPIO core with per-bit direction, edge-triggered sticky W1C status and a
// level irq. Define GPIO_DEBOUNCE_EN to add a per-pin debounce filter on the input path.
module gpio_irq_core
  import gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  gpio_irq_core_if.slave        bus,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_oe,
  output logic                  irq
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("gpio_irq_core: DATA_WIDTH must be 1..32 and DEBOUNCE_CYCLES at least 1");
  end

  logic [DATA_WIDTH-1:0] level;
  logic [DATA_WIDTH-1:0] rise_e;
  logic [DATA_WIDTH-1:0] fall_e;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
`ifdef GPIO_DEBOUNCE_EN
    gpio_pin_cond #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pin_cond (
      .clk  (clk),
      .reset(reset),
      .pin  (data_in[i]),
      .level(level[i]),
      .rise (rise_e[i]),
      .fall (fall_e[i])
    );
`else
    gpio_pin_cond u_pin_cond (
      .clk  (clk),
      .reset(reset),
      .pin  (data_in[i]),
      .level(level[i]),
      .rise (rise_e[i]),
      .fall (fall_e[i])
    );
`endif
  end

  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] dir_q;
  logic [DATA_WIDTH-1:0] ie_q;
  logic [DATA_WIDTH-1:0] rise_q;
  logic [DATA_WIDTH-1:0] fall_q;
  logic [DATA_WIDTH-1:0] stat_q;
  logic [DATA_WIDTH-1:0] stat_d;
  logic                  irq_q;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] set;
  logic [DATA_WIDTH-1:0] clr;

  assign wr_en = bus.cs & bus.write;
  assign wd    = bus.wr_data[DATA_WIDTH-1:0];

  // Output pins never raise status, whatever the edge masks say.
  assign set = ((rise_e & rise_q) | (fall_e & fall_q)) & ~dir_q;
  assign clr = (wr_en && bus.reg_addr == GPIO_REG_STAT) ? wd : '0;

  // Set is applied after the clear so a same-cycle event is never lost.
  assign stat_d = (stat_q & ~clr) | set;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      dir_q  <= '0;
      ie_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (bus.reg_addr)
          GPIO_REG_OUT:  out_q  <= wd;
          GPIO_REG_DIR:  dir_q  <= wd;
          GPIO_REG_IE:   ie_q   <= wd;
          GPIO_REG_RISE: rise_q <= wd;
          GPIO_REG_FALL: fall_q <= wd;
          default: ;
        endcase
      end
      stat_q <= stat_d;
      irq_q  <= |(stat_q & ie_q);
    end
  end

  logic [GPIO_BUS_WIDTH-1:0] rd;

  always_comb begin
    rd = '0;
    if (bus.cs && bus.read) begin
      case (bus.reg_addr)
        GPIO_REG_IN:   rd[DATA_WIDTH-1:0] = level;
        GPIO_REG_OUT:  rd[DATA_WIDTH-1:0] = out_q;
        GPIO_REG_DIR:  rd[DATA_WIDTH-1:0] = dir_q;
        GPIO_REG_IE:   rd[DATA_WIDTH-1:0] = ie_q;
        GPIO_REG_RISE: rd[DATA_WIDTH-1:0] = rise_q;
        GPIO_REG_FALL: rd[DATA_WIDTH-1:0] = fall_q;
        GPIO_REG_STAT: rd[DATA_WIDTH-1:0] = stat_q;
        default: ;
      endcase
    end
  end

  assign bus.rd_data = rd;
  assign data_out    = out_q;
  assign data_oe     = dir_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_gpio_irq_core.sv
// Bench for gpio_irq_core: directed register/edge scenarios plus random bus and pin traffic,
// all checked every cycle against a pin-history reference model.
module tb_gpio_irq_core;
  import gpio_pkg::*;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_oe;
  logic          irq;

  gpio_irq_core_if bus ();

  gpio_irq_core #(
    .DATA_WIDTH     (DW),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .data_in (data_in),
    .data_out(data_out),
    .data_oe (data_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state: register contents plus the pin values seen at the last three edges
  // (h1 newest). IN shows the pin as it was one edge before the latest one.
  logic [DW-1:0] m_out, m_dir, m_ie, m_rise, m_fall, m_stat;
  logic          m_irq;
  logic [DW-1:0] h1, h2, h3;
  logic [DW-1:0] pins = '0;
  logic [31:0]   last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_ie = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    m_irq = 1'b0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  function automatic logic [31:0] model_read(input gpio_addr_t a);
    logic [31:0] v;
    v = '0;
    case (a)
      GPIO_REG_IN:   v[DW-1:0] = h2;
      GPIO_REG_OUT:  v[DW-1:0] = m_out;
      GPIO_REG_DIR:  v[DW-1:0] = m_dir;
      GPIO_REG_IE:   v[DW-1:0] = m_ie;
      GPIO_REG_RISE: v[DW-1:0] = m_rise;
      GPIO_REG_FALL: v[DW-1:0] = m_fall;
      GPIO_REG_STAT: v[DW-1:0] = m_stat;
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_edge(input logic c, input logic w, input gpio_addr_t a,
                            input logic [31:0] wd, input logic rst);
    logic [DW-1:0] v, ev;
    if (rst) begin
      model_reset();
      return;
    end
    v = wd[DW-1:0];
    // A pin change lands in STAT on the third edge after it is first sampled.
    ev = ((h2 & ~h3 & m_rise) | (~h2 & h3 & m_fall)) & ~m_dir;
    m_irq = |(m_stat & m_ie);
    if (c && w) begin
      case (a)
        GPIO_REG_OUT:  m_out  = v;
        GPIO_REG_DIR:  m_dir  = v;
        GPIO_REG_IE:   m_ie   = v;
        GPIO_REG_RISE: m_rise = v;
        GPIO_REG_FALL: m_fall = v;
        GPIO_REG_STAT: m_stat = m_stat & ~v;
        default: ;
      endcase
    end
    m_stat = m_stat | ev;
    h3 = h2; h2 = h1; h1 = pins;
  endtask

  task automatic cycle(input logic c, input logic r, input logic w, input gpio_addr_t a,
                       input logic [31:0] wd, input logic rst);
    @(negedge clk);
    bus.cs = c; bus.read = r; bus.write = w; bus.reg_addr = a; bus.wr_data = wd;
    data_in = pins; reset = rst;
    #1;
    last_rd = bus.rd_data;
    check_eq("rd_data", bus.rd_data, (c && r) ? model_read(a) : 32'h0);
    check_eq("data_out", 32'(data_out), 32'(m_out));
    check_eq("data_oe", 32'(data_oe), 32'(m_dir));
    check_eq("irq", 32'(irq), 32'(m_irq));
    @(posedge clk);
    model_edge(c, w, a, wd, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic wr(input gpio_addr_t a, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input gpio_addr_t a);
    cycle(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] in_vals [3];
    gpio_addr_t    a;
    in_vals[0] = 12'h485; in_vals[1] = 12'h048; in_vals[2] = 12'hFFF;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.reg_addr = '0; bus.wr_data = '0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    model_reset();

    for (int i = 0; i < 8; i++) begin
      rd(5'(i));
      check_eq("reset_read", last_rd, 32'h0);
    end

    wr(GPIO_REG_DIR, 32'h0FF);
    wr(GPIO_REG_OUT, 32'hA5A);
    rd(GPIO_REG_OUT);
    check_eq("out_readback", last_rd, 32'hA5A);
    wr(GPIO_REG_DIR, 32'hFFFF_FFFF);
    rd(GPIO_REG_DIR);
    check_eq("dir_truncated", last_rd, 32'h0000_0FFF);
    wr(GPIO_REG_DIR, 32'h0);

    foreach (in_vals[k]) begin
      pins = in_vals[k];
      rd(GPIO_REG_IN);
      rd(GPIO_REG_IN);
      rd(GPIO_REG_IN);
      check_eq("in_after_2", last_rd, 32'(in_vals[k]));
    end
    pins = '0;
    idle(4);

    // Rising edge on bit0 into an enabled interrupt, then W1C.
    wr(GPIO_REG_RISE, 32'h001);
    wr(GPIO_REG_IE, 32'h001);
    pins[0] = 1'b1;
    for (int i = 0; i < 5; i++) rd(GPIO_REG_STAT);
    check_eq("stat_rise", last_rd, 32'h001);
    wr(GPIO_REG_STAT, 32'h001);
    idle(2);
    rd(GPIO_REG_STAT);
    check_eq("stat_cleared", last_rd, 32'h000);

    // Falling edge on bit1 whose status set coincides with a W1C of the same bit.
    wr(GPIO_REG_FALL, 32'h002);
    pins[1] = 1'b1;
    idle(4);
    pins[1] = 1'b0;
    idle(2);
    wr(GPIO_REG_STAT, 32'h002);
    rd(GPIO_REG_STAT);
    check_eq("set_beats_clear", last_rd, 32'h002);
    wr(GPIO_REG_STAT, 32'hFFF);

    // Output pin toggling: readable through IN but never flagged.
    wr(GPIO_REG_DIR, 32'h004);
    wr(GPIO_REG_RISE, 32'h004);
    wr(GPIO_REG_FALL, 32'h004);
    for (int i = 0; i < 6; i++) begin
      pins[2] = ~pins[2];
      rd(GPIO_REG_IN);
      rd(GPIO_REG_IN);
      rd(GPIO_REG_IN);
    end
    rd(GPIO_REG_STAT);
    check_eq("dir_out_no_stat", last_rd, 32'h000);

    // Random bus and pin traffic with occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      logic c, r, w, rst;
      a = ($urandom_range(0, 9) > 7) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      c   = ($urandom_range(0, 7) != 0);
      r   = $urandom_range(0, 1) == 1;
      w   = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) == 0);
      pins = pins ^ DW'($urandom & $urandom & $urandom);
      cycle(c, r, w, a, $urandom, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_irq_core.md
Name: gpio_irq_core

Overview:
- Next-generation parametrised GPIO core on the MicroBlaze register bus (cs/read/write/reg_addr/wr_data/rd_data).
- Replaces whole-port mode control with per-bit direction.
- Adds a 2-flop input synchroniser, per-bit rising/falling edge detection, sticky write-1-to-clear (W1C) interrupt status and a level irq output to the interrupt controller.

Parameters:
- DATA_WIDTH, 12, number of GPIO pins (1..32).
- DEBOUNCE_CYCLES, 16, stable cycles required by the debounce filter; used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  chip select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- reg_addr  in  5  word register address.
- wr_data  in  32  write data.
- rd_data  out  32  read data.
- data_in  in  DATA_WIDTH  external pin inputs (asynchronous).
- data_out  out  DATA_WIDTH  output data register.
- data_oe  out  DATA_WIDTH  per-bit output enable (1 = drive).
- irq  out  1  level interrupt.

Behaviour:
- Register map:
  - 0 IN: read-only, conditioned input.
  - 1 OUT: read/write.
  - 2 DIR: read/write; 1 = output.
  - 3 IE: read/write, interrupt enable.
  - 4 RISE: read/write, rising-edge mask.
  - 5 FALL: read/write, falling-edge mask.
  - 6 STAT: read; write-1-to-clear.
  - 7..31: unmapped; read 0, writes ignored.
- Write: takes effect on the rising clk edge where cs & write = 1. Bits [31:DATA_WIDTH] are ignored on write and read as 0.
- Read: rd_data is combinational. It equals the addressed register zero-extended when cs & read = 1, else 0.
- Reset: all registers, synchroniser/edge flops, STAT and irq clear to 0. data_out = 0, data_oe = 0 (all pins inputs), rd_data = 0.
- Outputs: data_out = OUT and data_oe = DIR, driven directly from the registers; both update the cycle after the write edge.
- Input path: data_in -> s1 -> s2 (two flops). IN reads s2, so a pin change is visible in IN after 2 clk edges.
- Edge detect: prev is registered s2.
  - rise = s2 & ~prev & RISE & ~DIR.
  - fall = ~s2 & prev & FALL & ~DIR.
- STAT: bit sets on the edge after rise|fall is asserted, i.e. 3 edges after the pin changes.
  - Sticky until cleared by a W1C write to addr 6.
  - Simultaneous set and clear on the same bit: set wins.
- irq = registered |(STAT & IE), asserted the cycle after the STAT bit sets. Clearing IE or STAT drops irq one cycle later.
- Pins with DIR = 1 never set STAT; IN still reflects data_in for them (loopback readable).
- Changing RISE/FALL masks: no retroactive status; only edges detected after the mask write count.
- A pin held high through reset release produces a rise pulse 2 cycles after reset; it is discarded because masks are 0.
- Reset asserted mid-operation: everything returns to reset values on that edge. No pending interrupt survives.

Optional Feature:
- GPIO_DEBOUNCE_EN defined:
  - Each pin has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The filtered bit f takes s2 only after s2 != f for DEBOUNCE_CYCLES consecutive cycles.
  - The counter clears whenever s2 == f.
  - IN and edge detection use f instead of s2. Added latency is DEBOUNCE_CYCLES cycles.
  - Counters and f reset to 0.
- GPIO_DEBOUNCE_EN undefined: f = s2, with no counters synthesised.

Decomposition:
- gpio_pkg holds:
  - register address localparams (GPIO_REG_IN .. GPIO_REG_STAT);
  - the bus width constant 32;
  - a typedef for the 5-bit register address.
- Sub-module gpio_pin_cond: one pin's synchroniser, optional debounce, prev flop and rise/fall outputs. It is instantiated DATA_WIDTH times via generate.

Test Plan (DATA_WIDTH = 12):
- Reset held 5 cycles, then read addrs 0..7 -> all 0x00000000; data_oe = 0x000, irq = 0.
- Write DIR = 0x0FF, OUT = 0xA5A -> data_out = 0xA5A and data_oe = 0x0FF on the next cycle. Write DIR = 0xFFFFFFFF -> reads 0x00000FFF.
- DIR = 0, data_in = 0x485 -> IN reads 0x000 after 1 edge and 0x485 after 2 edges. Same check for 0x048 and 0xFFF.
- RISE = 0x001, IE = 0x001, data_in bit0 0->1 -> STAT = 0x001 at edge 3 and irq = 1 at edge 4. Write 0x001 to STAT -> STAT = 0 and irq = 0 one cycle later.
- FALL = 0x002, bit1 1->0 timed so the STAT set lands on the same edge as a W1C of 0x002 -> STAT bit1 remains 1.
- DIR bit2 = 1, RISE = FALL = 0x004, toggle data_in bit2 -> STAT stays 0 and IN bit2 follows the pin.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES = 16: a 10-cycle pulse on bit3 -> IN unchanged, no STAT. A 20-cycle level -> IN bit3 = 1 after 2 + 16 cycles.
